// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types, FU request index map and sizing constants for the result bus.
package sys_defs;

    localparam int NUM_FU_ALU  = 3;
    localparam int NUM_FU_MULT = 2;
    localparam int NUM_FU_LOAD = 3;
    localparam int NUM_REQ     = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LOAD;
    localparam int CDB_WIDTH   = 2;
    localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Request port index map: ALU ports first, then MULT, then LOAD
    localparam int REQ_ALU_BASE  = 0;
    localparam int REQ_MULT_BASE = REQ_ALU_BASE + NUM_FU_ALU;
    localparam int REQ_LOAD_BASE = REQ_MULT_BASE + NUM_FU_MULT;

    localparam int PRN_W  = 6;
    localparam int DATA_W = 32;
    localparam int ROBN_W = 5;

    typedef logic [PRN_W-1:0]  PRN;
    typedef logic [DATA_W-1:0] DATA;
    typedef logic [ROBN_W-1:0] ROBN;

    typedef struct packed {
        PRN  dest_prn;
        DATA value;
        ROBN robn;
    } FU_RESULT;

    typedef struct packed {
        logic valid;
        PRN   dest_prn;
        DATA  value;
        ROBN  robn;
    } CDB_PACKET;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-result request bus and CDB broadcast; master = FU side, slave = arbiter.
interface cdb_arbiter_if;
    import sys_defs::*;

    logic [NUM_REQ-1:0]              req_valid;
    FU_RESULT [NUM_REQ-1:0]          req_result;
    logic [NUM_REQ-1:0]              req_ready;
    CDB_PACKET [CDB_WIDTH-1:0]       cdb_packet;

    modport master (
        output req_valid,
        output req_result,
        input  req_ready,
        input  cdb_packet
    );

    modport slave (
        input  req_valid,
        input  req_result,
        output req_ready,
        output cdb_packet
    );
endinterface

// File: rtl/cdb_arbiter_sel.sv
// Combinational multi-grant selector: scans from start_ptr and hands out up to WIDTH
// one-hot grants in scan order; last_idx is the final granted index.
module rr_multi_sel #(
    parameter int WIDTH   = 2,
    parameter int NUM_REQ = 8,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]            req,
    input  logic [IDX_W-1:0]              start_ptr,
    output logic [WIDTH-1:0][NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]              last_idx
);

    int cnt;
    int idx;

    always_comb begin
        grant    = '0;
        last_idx = start_ptr;
        cnt      = 0;
        idx      = 0;
        for (int o = 0; o < NUM_REQ; o++) begin
            idx = int'(start_ptr) + o;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx] && (cnt < WIDTH)) begin
                grant[cnt][idx] = 1'b1;
                last_idx        = IDX_W'(idx);
                cnt             = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to CDB_WIDTH FU results per cycle, broadcasts them
// one cycle later. CDB_RR_EN selects rotating priority; otherwise index 0 always wins.
module cdb_arbiter
    import sys_defs::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          squash,
    cdb_arbiter_if.slave  cdb
);

    logic [NUM_REQ-1:0]              sel_req;
    logic [CDB_WIDTH-1:0][NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]                last_idx;
    logic [IDX_W-1:0]                start_ptr;
    logic [NUM_REQ-1:0]              ready;
    CDB_PACKET [CDB_WIDTH-1:0]       pkt_nxt;

    // Reset and squash both suppress every grant, so nothing is consumed from the FUs
    assign sel_req = (reset || squash) ? '0 : cdb.req_valid;

    rr_multi_sel #(
        .WIDTH   (CDB_WIDTH),
        .NUM_REQ (NUM_REQ)
    ) u_sel (
        .req       (sel_req),
        .start_ptr (start_ptr),
        .grant     (grant),
        .last_idx  (last_idx)
    );

    always_comb begin
        ready = '0;
        for (int k = 0; k < CDB_WIDTH; k++) ready = ready | grant[k];
    end

    assign cdb.req_ready = ready;

    always_comb begin
        for (int k = 0; k < CDB_WIDTH; k++) begin
            pkt_nxt[k] = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[k][i]) begin
                    pkt_nxt[k] = CDB_PACKET'({1'b1, cdb.req_result[i]});
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) cdb.cdb_packet <= '0;
        else       cdb.cdb_packet <= pkt_nxt;
    end

`ifdef CDB_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (|ready) begin
            rr_ptr <= (last_idx == IDX_W'(NUM_REQ - 1)) ? '0 : last_idx + IDX_W'(1);
        end
    end

    assign start_ptr = rr_ptr;
`else
    logic [IDX_W-1:0] unused_last_idx;

    assign start_ptr       = '0;
    assign unused_last_idx = last_idx;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based scan model checked every cycle plus directed literals.
module tb_cdb_arbiter;
    import sys_defs::*;

`ifdef CDB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic squash;

    always #5 clock = ~clock;

    cdb_arbiter_if ifc ();

    cdb_arbiter dut (
        .clock  (clock),
        .reset  (reset),
        .squash (squash),
        .cdb    (ifc.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // ---------------- behavioural model ----------------
    int                        m_ptr   = 0;
    bit                        m_known = 1'b0;
    CDB_PACKET [CDB_WIDTH-1:0] m_pkt   = '0;
    CDB_PACKET [CDB_WIDTH-1:0] nxt;
    logic [NUM_REQ-1:0]        m_grant = '0;
    logic [NUM_REQ-1:0]        m_took  = '0;
    int                        nxt_ptr;
    bit                        nxt_rst;
    int                        q[$];
    int                        st, idx, take;
    bit                        sb_on = 1'b0;
    bit                        outstanding[int unsigned];

    always begin
        @(negedge clock);
        // candidate list = valid requesters in scan order; the first CDB_WIDTH win
        q.delete();
        st = RR ? m_ptr : 0;
        for (int o = 0; o < NUM_REQ; o++) begin
            idx = (st + o) % NUM_REQ;
            if (ifc.req_valid[idx]) q.push_back(idx);
        end
        if (reset || squash) q.delete();
        take    = (q.size() < CDB_WIDTH) ? q.size() : CDB_WIDTH;
        m_grant = '0;
        nxt     = '0;
        for (int k = 0; k < take; k++) begin
            m_grant[q[k]] = 1'b1;
            nxt[k]        = CDB_PACKET'({1'b1, ifc.req_result[q[k]]});
        end
        nxt_rst = reset;
        nxt_ptr = reset ? 0 : ((take > 0) ? (q[take-1] + 1) % NUM_REQ : m_ptr);

        chk("req_ready", ifc.req_ready, m_grant);
        if (m_known) chk("cdb_packet", ifc.cdb_packet, m_pkt);
        if (sb_on && m_known) begin
            for (int k = 0; k < CDB_WIDTH; k++) begin
                if (ifc.cdb_packet[k].valid) begin
                    n_chk++;
                    if (outstanding.exists(ifc.cdb_packet[k].value)) begin
                        n_pass++;
                        outstanding.delete(ifc.cdb_packet[k].value);
                    end else begin
                        $display("FAIL sb_unique: got value %0h expected an outstanding result",
                                 ifc.cdb_packet[k].value);
                    end
                end
            end
        end

        @(posedge clock);
        m_pkt   = nxt;
        m_ptr   = nxt_ptr;
        m_took  = m_grant;
        m_known = m_known || nxt_rst;
    end

    // ---------------- directed + random stimulus ----------------
    logic [7:0]  exp_sat[5];
    CDB_PACKET   exp_single;
    int unsigned serial = 32'h0001_0000;
    bit          drained;

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic mid_cycle();
        @(negedge clock);
        #1;
    endtask

    task automatic default_results();
        for (int i = 0; i < NUM_REQ; i++)
            ifc.req_result[i] = '{dest_prn: PRN'(i + 1), value: DATA'(32'h1000 + i), robn: ROBN'(i)};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        squash        = 1'b0;
        ifc.req_valid = 8'hFF;
        default_results();
        if (RR) begin
            exp_sat[0] = 8'h03; exp_sat[1] = 8'h0C; exp_sat[2] = 8'h30;
            exp_sat[3] = 8'hC0; exp_sat[4] = 8'h03;
        end else begin
            for (int c = 0; c < 5; c++) exp_sat[c] = 8'h03;
        end

        // reset with all requesters valid
        mid_cycle();
        chk("reset_ready", ifc.req_ready, 8'h00);
        chk("reset_pkt", ifc.cdb_packet, '0);
        next_cycle();
        chk("reset_ready2", ifc.req_ready, 8'h00);
        chk("reset_pkt2", ifc.cdb_packet, '0);
        reset = 1'b0;

        // saturation
        for (int c = 0; c < 5; c++) begin
            mid_cycle();
            chk("sat_ready", ifc.req_ready, exp_sat[c]);
            if (c == 1) begin
                chk("sat_slot0", ifc.cdb_packet[0].value, 32'h1000);
                chk("sat_slot1", ifc.cdb_packet[1].value, 32'h1001);
            end
            next_cycle();
        end

        // single request on port 5
        ifc.req_valid     = 8'h20;
        ifc.req_result[5] = '{dest_prn: 6'd7, value: 32'hDEAD, robn: 5'd3};
        mid_cycle();
        chk("single_ready", ifc.req_ready, 8'h20);
        next_cycle();
        ifc.req_valid = 8'h40;
        exp_single    = '{valid: 1'b1, dest_prn: 6'd7, value: 32'hDEAD, robn: 5'd3};
        mid_cycle();
        chk("single_slot0", ifc.cdb_packet[0], exp_single);
        chk("single_slot1", ifc.cdb_packet[1], '0);
        chk("p6_ready", ifc.req_ready, 8'h40);
        next_cycle();
        default_results();

        // wrap: requesters 7, 0, 3
        ifc.req_valid = 8'h89;
        mid_cycle();
        chk("wrap_ready", ifc.req_ready, RR ? 8'h81 : 8'h09);
        next_cycle();
        ifc.req_valid = RR ? 8'h08 : 8'h80;
        mid_cycle();
        chk("wrap_slot0", ifc.cdb_packet[0].value, RR ? 32'h1007 : 32'h1000);
        chk("wrap_slot1", ifc.cdb_packet[1].value, RR ? 32'h1000 : 32'h1003);
        chk("wrap_ready2", ifc.req_ready, RR ? 8'h08 : 8'h80);
        next_cycle();
        ifc.req_valid = 8'h00;
        mid_cycle();
        chk("wrap_slot0b", ifc.cdb_packet[0].value, RR ? 32'h1003 : 32'h1007);
        chk("wrap_slot1b", ifc.cdb_packet[1].valid, 1'b0);
        next_cycle();

        // squash
        ifc.req_valid = 8'h0C;
        squash        = 1'b1;
        mid_cycle();
        chk("squash_ready", ifc.req_ready, 8'h00);
        next_cycle();
        squash = 1'b0;
        mid_cycle();
        chk("squash_pkt", ifc.cdb_packet, '0);
        chk("unsquash_ready", ifc.req_ready, 8'h0C);
        next_cycle();
        ifc.req_valid = 8'h00;
        mid_cycle();
        chk("unsquash_slot0", ifc.cdb_packet[0].value, 32'h1002);
        chk("unsquash_slot1", ifc.cdb_packet[1].value, 32'h1003);
        next_cycle();
        next_cycle();
        next_cycle();

        // random hold/retry with no-loss / no-duplicate scoreboard
        sb_on = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ifc.req_valid[i] && m_took[i]) ifc.req_valid[i] = 1'b0;
                if (!ifc.req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    serial++;
                    ifc.req_result[i] = '{dest_prn: PRN'($urandom_range(0, 63)),
                                          value: DATA'(serial),
                                          robn: ROBN'($urandom_range(0, 31))};
                    outstanding[serial] = 1'b1;
                    ifc.req_valid[i]    = 1'b1;
                end
            end
            squash = ($urandom_range(0, 9) == 0);
            next_cycle();
        end

        squash  = 1'b0;
        drained = 1'b0;
        for (int c = 0; c < 300 && !drained; c++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (ifc.req_valid[i] && m_took[i]) ifc.req_valid[i] = 1'b0;
            if (ifc.req_valid == '0) drained = 1'b1;
            else next_cycle();
        end
        next_cycle();
        next_cycle();
        chk("drain_done", ifc.req_valid, '0);
        chk("sb_empty", outstanding.num(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
